// File: rtl/fifo_width_downsizer.sv
// Read stage for the show-ahead synchronous FIFO: pops one DATA_WIDTH word at a time
// and serialises it onto a valid/ready stream as DATA_WIDTH/OUT_WIDTH chunks.
module fifo_width_downsizer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rData,
  output logic                  fifo_rEn,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_last
);

  localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_SEND  = 1'b1;

  logic                  state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  logic                  loaded_s;
  logic                  last_s;
  logic                  xfer_s;
  logic                  load_ok_s;
  logic                  pop_s;
  logic [IDX_W-1:0]      sel_s;
  logic [OUT_WIDTH-1:0]  chunk_s;

  assign loaded_s  = (state_q == ST_SEND);
  assign last_s    = loaded_s & (idx_q == LAST_IDX);
  assign xfer_s    = loaded_s & m_ready;
  // The next word may be popped in the same cycle the final chunk leaves, so no bubble.
  assign load_ok_s = ~loaded_s | (xfer_s & last_s);
  // arst_n is folded in so the pop request drops asynchronously with reset.
  assign pop_s     = ~fifo_empty & load_ok_s & ~flush & arst_n;

  assign fifo_rEn = pop_s;
  assign m_valid  = loaded_s;
  assign m_last   = last_s;
  assign m_data   = chunk_s;

  // Next-state: flush beats load, load beats chunk advance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    if (flush) begin
      state_d = ST_EMPTY;
      idx_d   = '0;
    end else if (pop_s) begin
      state_d = ST_SEND;
      idx_d   = '0;
      word_d  = fifo_rData;
    end else begin
      case (state_q)
        ST_SEND: begin
          if (m_ready) begin
            if (last_s) begin
              state_d = ST_EMPTY;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end else begin
            idx_d = idx_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Chunk mux: MSB-first order simply mirrors the index.
  always_comb begin
    sel_s   = LSB_FIRST ? idx_q : (LAST_IDX - idx_q);
    chunk_s = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (sel_s == IDX_W'(i)) begin
        chunk_s = word_q[i*OUT_WIDTH +: OUT_WIDTH];
      end else begin
        chunk_s = chunk_s;
      end
    end
  end

  // State, index and word registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: doc/fifo_width_downsizer.md
# fifo_width_downsizer

Downstream read stage for the team's synchronous FIFO. It pops DATA_WIDTH-bit words from the FIFO read port (empty / rEn / show-ahead rData) and serialises each word into DATA_WIDTH/OUT_WIDTH narrower chunks on a valid/ready master stream. Typical use: a 32-bit FIFO feeding an 8-bit byte consumer such as a UART TX or SPI shifter. It runs back-to-back at one chunk per clock with no bubble between words.

## Interface
- DATA_WIDTH, 32, FIFO word width; must equal the FIFO's DATA_WIDTH.
- OUT_WIDTH, 8, output chunk width; DATA_WIDTH must be an integer multiple of OUT_WIDTH (RATIO = DATA_WIDTH/OUT_WIDTH ≥ 1).
- LSB_FIRST, 1, 1: chunk 0 = bits [OUT_WIDTH-1:0]; 0: chunk 0 = most-significant chunk.

- clk  input  1  single clock; all state updates on posedge.
- arst_n  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rData  input  DATA_WIDTH  FIFO head word; valid whenever fifo_empty=0 (show-ahead).
- fifo_rEn  output  1  pop request; the FIFO advances on the clock edge where this is 1.
- flush  input  1  synchronous discard of the word currently being serialised.
- m_valid  output  1  chunk on m_data is valid.
- m_ready  input  1  consumer accepts the chunk this cycle.
- m_data  output  OUT_WIDTH  current chunk.
- m_last  output  1  high with the final chunk of each word.

## Operation
- State: word register buf[DATA_WIDTH], chunk index idx (width max(1,$clog2(RATIO))), loaded flag (drives m_valid).
- States:
  - EMPTY: loaded=0.
  - SEND: loaded=1, idx = 0..RATIO-1.
- Handshake: xfer = m_valid & m_ready.
- Load condition: load_ok = !loaded | (xfer & m_last). It is combinational.
- fifo_rEn = !fifo_empty & load_ok & !flush & arst_n. Pops are never issued while fifo_empty=1 or during reset.
- On a clock edge with fifo_rEn=1: buf <= fifo_rData, idx <= 0, loaded <= 1.
- On a clock edge with xfer and !m_last (no load): idx <= idx+1.
- On a clock edge with xfer & m_last and no load: loaded <= 0, idx <= 0.
- flush=1 (priority over everything except reset): loaded <= 0, idx <= 0, fifo_rEn=0 that cycle. A chunk handshaken in the same cycle still counts as accepted. Remaining chunks of that word are dropped.
- m_data:
  - LSB_FIRST=1: buf[idx*OUT_WIDTH +: OUT_WIDTH].
  - LSB_FIRST=0: buf[(RATIO-1-idx)*OUT_WIDTH +: OUT_WIDTH].
- m_last = loaded & (idx == RATIO-1). With RATIO=1, m_last = m_valid.
- Stream rules:
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
  - m_valid never falls without a handshake, except on flush or reset.
  - m_valid does not depend combinationally on m_ready.
- Index arithmetic is unsigned. idx never exceeds RATIO-1; it does not wrap except via load.

## Timing
- Reset values (async on arst_n low): loaded=0, idx=0, buf=0. Outputs are therefore m_valid=0, m_last=0, m_data=0, fifo_rEn=0.
- Load latency: when fifo_empty=0 in cycle N with the block EMPTY, fifo_rEn=1 in N and m_valid=1 in N+1 with chunk 0.
- Throughput: with m_ready held at 1 and the FIFO non-empty, one chunk per cycle. The last chunk of word k and the pop of word k+1 occur in the same cycle, so chunk 0 of k+1 follows in the next cycle with no gap.
- Boundary cases:
  - FIFO empty at the m_last handshake: the block goes EMPTY, m_valid=0 next cycle, and reloads on the first cycle fifo_empty=0.
  - m_ready=0 on the last chunk: no pop until that chunk is accepted.
  - Reset mid-word: the word is discarded. fifo_rEn is low immediately and asynchronously.
  - flush while EMPTY: no effect, but the pop is suppressed that cycle.

## Test plan
- Reset: assert arst_n=0 with fifo_empty=0 -> fifo_rEn=0 and m_valid=0 throughout. After release, the first pop occurs on the first clock.
- Single word, LSB_FIRST=1, 32→8: FIFO holds 32'hA1B2C3D4, m_ready=1 -> m_data D4, C3, B2, A1 on 4 consecutive cycles. m_last is high only with A1, then m_valid=0.
- Back-to-back: FIFO holds 32'h03020100 and 32'h07060504, m_ready=1 -> chunks 00..07 on 8 consecutive cycles with no gap. fifo_rEn pulses in cycle 0 and cycle 4.
- Backpressure: toggle m_ready 1,0,0,1,… -> no chunk lost or duplicated. m_data stays stable while stalled. A word with LSB_FIRST=0 and value 32'h11223344 emits 11, 22, 33, 44.
- Flush: flush=1 after chunk 1 of 32'hDEADBEEF is accepted -> m_valid=0 next cycle. The next FIFO word 32'h00000055 yields 55, 00, 00, 00.
- Empty boundary: a single word with the FIFO then empty -> no fifo_rEn while empty. A word written 5 cycles later is popped in the cycle fifo_empty falls.
